as_ctrl: RTL

- Instruction sequencer and decoder for the as embedded processor.
- Fetches instruction words from a synchronous program memory and holds them in an instruction register.
- Decodes each instruction and drives the control inputs of the ALU/ACC datapath: input selectors, ACC enable, ACC feedback, switch routing and register-file write.
- Consumes the ALU zero flag to resolve branches. It is the initiator side of the ALU control interface.

---
 rtl/as_pkg.sv | 33 +++
 rtl/as_decode.sv | 24 ++
 rtl/as_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/as_pkg.sv
// as_pkg: opcodes, FSM states, instruction field positions and datapath control bundle for the as sequencer.
package as_pkg;
   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADDI = 4'd1,
      OP_MLA  = 4'd2,
      OP_IN   = 4'd3,
      OP_ACCI = 4'd4,
      OP_ACCM = 4'd5,
      OP_BSW  = 4'd6,
      OP_JMP  = 4'd7,
      OP_BZR  = 4'd8,
      OP_HALT = 4'd15
   } opcode_t;
   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
   localparam int OP_MSB  = 17;
   localparam int OP_LSB  = 14;
   localparam int RD_MSB  = 13;
   localparam int RD_LSB  = 11;
   localparam int RS_MSB  = 10;
   localparam int RS_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;
   localparam int TGT_LSB = 8;
   typedef struct packed {
      logic add_a_sel;
      logic add_b_sel;
      logic acc_en;
      logic acc_add;
      logic in_en;
      logic reg_we;
   } ctrl_t;
endpackage

// File: rtl/as_decode.sv
// as_decode: combinational opcode to datapath controls and flow-control flags; unlisted opcodes decode as NOP.
module as_decode
   import as_pkg::*;
(
   input  logic [3:0] i_op,
   output ctrl_t      o_ctrl,
   output logic       o_is_branch,
   output logic       o_is_jump,
   output logic       o_is_halt
);
   opcode_t w_op;
   assign w_op = opcode_t'(i_op);
   always_comb begin
      o_ctrl.add_a_sel = w_op == OP_BSW;
      o_ctrl.add_b_sel = w_op inside {OP_ADDI, OP_ACCI, OP_BSW, OP_BZR};
      o_ctrl.acc_en    = w_op inside {OP_ACCI, OP_ACCM};
      o_ctrl.acc_add   = w_op inside {OP_ACCI, OP_ACCM};
      o_ctrl.in_en     = w_op == OP_IN;
      o_ctrl.reg_we    = w_op inside {OP_ADDI, OP_MLA, OP_IN};
      o_is_branch      = w_op inside {OP_BSW, OP_BZR};
      o_is_jump        = w_op == OP_JMP;
      o_is_halt        = w_op == OP_HALT;
   end
endmodule

// File: rtl/as_ctrl.sv
// as_ctrl: 3-cycle fetch/decode/exec sequencer driving the ALU/ACC datapath controls.
// Defining AS_SINGLE_STEP_EN adds a step button; each rising edge seen in FETCH runs one instruction.
module as_ctrl
   import as_pkg::*;
#(
   parameter int N  = 8,
   parameter int PW = 6,
   parameter int IW = 18
) (
   input  logic          clk,
   input  logic          n_reset,
`ifdef AS_SINGLE_STEP_EN
   input  logic          step,
`endif
   output logic [PW-1:0] imem_addr,
   input  logic [IW-1:0] imem_rdata,
   input  logic          z,
   output logic [2:0]    rd_addr,
   output logic [2:0]    rs_addr,
   output logic [N-1:0]  immediate,
   output logic          add_a_sel,
   output logic          add_b_sel,
   output logic          acc_en,
   output logic          acc_add,
   output logic          in_en,
   output logic          reg_we,
   output logic [PW-1:0] pc,
   output logic          halted
);
   state_t        r_state;
   logic [PW-1:0] r_pc;
   logic [IW-1:0] r_ir;
   ctrl_t         w_dec;
   ctrl_t         w_ctrl;
   logic          w_branch;
   logic          w_jump;
   logic          w_halt;
   logic          w_taken;
   logic          w_go;
`ifdef AS_SINGLE_STEP_EN
   logic [1:0]    r_sync;
   logic          r_prev;
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], step};
         r_prev <= r_sync[1];
      end
   end
   // an edge is only consumed by FETCH; elsewhere it simply expires
   assign w_go = r_sync[1] & ~r_prev;
`else
   assign w_go = 1'b1;
`endif
   as_decode u_decode (
      .i_op       (r_ir[OP_MSB:OP_LSB]),
      .o_ctrl     (w_dec),
      .o_is_branch(w_branch),
      .o_is_jump  (w_jump),
      .o_is_halt  (w_halt)
   );
   assign w_taken = w_jump | (w_branch & z);
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         case (r_state)
            FETCH:  r_state <= w_go ? DECODE : FETCH;
            DECODE: begin
               r_ir    <= imem_rdata;
               r_state <= EXEC;
            end
            EXEC: begin
               r_state <= w_halt ? HALT : FETCH;
               r_pc    <= w_halt ? r_pc : w_taken ? r_ir[TGT_LSB +: PW] : r_pc + 1'b1;
            end
            default: r_state <= HALT;
         endcase
      end
   end
   // gating on the registered state drops every enable as soon as reset hits
   assign w_ctrl    = (r_state == EXEC) ? w_dec : '0;
   assign {add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we} = w_ctrl;
   assign rd_addr   = r_ir[RD_MSB:RD_LSB];
   assign rs_addr   = r_ir[RS_MSB:RS_LSB];
   assign immediate = N'($signed(r_ir[IMM_MSB:IMM_LSB]));
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign halted    = r_state == HALT;
endmodule
